sync_fifo_prog: RTL

Parametrised, vendor-independent synchronous FIFO. It is the next generation of the project's single-clock FIFO wrapper and is written in portable RTL with no vendor macro. It adds selectable standard or first-word-fall-through read mode, runtime-visible occupancy, programmable empty and full thresholds, overflow and underflow error pulses, and a synchronous flush. It is used as the TX/RX buffer in the UART datapath and by any single-clock stream buffer.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_ram.sv | 29 ++
 rtl/sync_fifo_prog.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO family.
//   fifo_mode_e     : read-port behaviour (standard registered read or first-word-fall-through)
//   fifo_count_w()  : width of an occupancy counter able to hold 0..depth
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int fifo_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous (flop-array) read.
// Contents are not reset.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
module sync_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with selectable standard / FWFT read mode, occupancy
// output, fixed and programmable thresholds, error pulses and sync flush.
//   clk, resetn        : clock, async active-low reset
//   clear              : synchronous flush (beats wr_en/rd_en)
//   wr_en, din         : write request / data
//   rd_en              : read request (pop in FWFT mode)
//   dout, data_valid   : read data and its qualifier
//   full, almost_full, prog_full, empty, almost_empty, prog_empty : occupancy flags
//   overflow/underflow : one-cycle pulse after a rejected write/read
//   data_count         : words stored, 0..FIFO_DEPTH
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int         FIFO_WIDTH        = 32,
    parameter int         FIFO_DEPTH        = 16,
    parameter fifo_mode_e READ_MODE         = FIFO_MODE_STD,
    parameter int         PROG_FULL_THRESH  = FIFO_DEPTH - 6,
    parameter int         PROG_EMPTY_THRESH = 3
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                clear,
    input  logic                                wr_en,
    input  logic [FIFO_WIDTH-1:0]               din,
    input  logic                                rd_en,
    output logic [FIFO_WIDTH-1:0]               dout,
    output logic                                data_valid,
    output logic                                full,
    output logic                                almost_full,
    output logic                                prog_full,
    output logic                                empty,
    output logic                                almost_empty,
    output logic                                prog_empty,
    output logic                                overflow,
    output logic                                underflow,
    output logic [fifo_count_w(FIFO_DEPTH)-1:0] data_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = fifo_count_w(FIFO_DEPTH);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_prog: FIFO_DEPTH must be a power of 2 and >= 4");
    end
    if (PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH >= PROG_FULL_THRESH ||
        PROG_FULL_THRESH > FIFO_DEPTH - 1) begin : g_bad_thresh
        $error("sync_fifo_prog: need 1 <= PROG_EMPTY_THRESH < PROG_FULL_THRESH <= FIFO_DEPTH-1");
    end

    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_acc, rd_acc;
    logic [FIFO_WIDTH-1:0] rd_data;

    // Flags come only from the registered count: no wr_en/rd_en -> flag path.
    assign empty        = (count == '0);
    assign full         = (count == CW'(FIFO_DEPTH));
    assign almost_full  = (count >= CW'(FIFO_DEPTH - 1));
    assign prog_full    = (count >= CW'(PROG_FULL_THRESH));
    assign almost_empty = (count <= CW'(1));
    assign prog_empty   = (count <= CW'(PROG_EMPTY_THRESH));
    assign data_count   = count;

    // No bypass: a read on an empty FIFO is rejected even with a write in flight.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

    sync_fifo_ram #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & ~clear),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    if (READ_MODE == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is shown directly; masked to zero while empty so the
        // output is defined (0) out of reset instead of stale RAM contents.
        assign dout       = empty ? '0 : rd_data;
        assign data_valid = ~empty;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] dout_q;
        logic                  dv_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else if (clear) begin
                dv_q   <= 1'b0;          // dout keeps its last value
            end else begin
                if (rd_acc) dout_q <= rd_data;
                dv_q <= rd_acc;
            end
        end

        assign dout       = dout_q;
        assign data_valid = dv_q;
    end

endmodule
